// File: rtl/tl_ctrl_xing_arbiter_if.sv
// TileLink-UL control-crossing link with LANES requesters packed side by side.
// The D payload is shared by every lane; only d_valid/d_ready are per lane.
interface tl_ctrl_xing_arbiter_if #(
  parameter int LANES = 1,
  parameter int SRC_W = 9
);
  logic [LANES-1:0]       a_valid;
  logic [LANES-1:0]       a_ready;
  logic [3*LANES-1:0]     a_bits_opcode;
  logic [3*LANES-1:0]     a_bits_param;
  logic [2*LANES-1:0]     a_bits_size;
  logic [SRC_W*LANES-1:0] a_bits_source;
  logic [29*LANES-1:0]    a_bits_address;
  logic [8*LANES-1:0]     a_bits_mask;
  logic [64*LANES-1:0]    a_bits_data;
  logic [LANES-1:0]       a_bits_corrupt;

  logic [LANES-1:0]       d_valid;
  logic [LANES-1:0]       d_ready;
  logic [2:0]             d_bits_opcode;
  logic [1:0]             d_bits_size;
  logic [SRC_W-1:0]       d_bits_source;
  logic [63:0]            d_bits_data;

  modport master (
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready,
    input  a_ready, d_valid, d_bits_opcode, d_bits_size, d_bits_source, d_bits_data
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready,
    output a_ready, d_valid, d_bits_opcode, d_bits_size, d_bits_source, d_bits_data
  );
endinterface

// File: rtl/tl_ctrl_xing_arbiter.sv
// Round-robin arbiter sharing one TL-UL control-crossing port between N requesters.
// A stalled beat locks the grant; D responses route back by the prepended index.
module tl_ctrl_xing_arbiter #(
  parameter int N       = 4,
  parameter int SRC_W   = 9,
  parameter int IDX_W   = $clog2(N),
  parameter int MAX_OUT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_ctrl_xing_arbiter_if.slave  in_tl,
  tl_ctrl_xing_arbiter_if.master out_tl,
  output logic                   err_unmapped
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  state_t         state, state_nxt;
  idx_t           rr_ptr, lock_idx, rr_pick, grant, d_idx;
  cnt_t           cnt [N];
  logic [N-1:0]   eligible, cnt_zero, inc, dec, d_sel;
  logic           a_valid, a_fire, d_mapped, d_fire;
  int             gi;
  int             j;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    eligible = '0;
    cnt_zero = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = in_tl.a_valid[i] && (cnt[i] < cnt_t'(MAX_OUT));
      cnt_zero[i] = (cnt[i] == '0);
    end
  end

  // First eligible requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    rr_pick = rr_ptr;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (eligible[j]) rr_pick = idx_t'(j);
    end
  end

  // Lock FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_OPEN;
    else        state <= state_nxt;
  end

  // Lock FSM: next state. A beat that is offered but not taken pins the grant.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_OPEN:   if (a_valid && !out_tl.a_ready[0]) state_nxt = ST_LOCKED;
      ST_LOCKED: if (a_fire) state_nxt = ST_OPEN;
      default:   state_nxt = ST_OPEN;
    endcase
  end

  // Lock FSM: outputs -- grant, A mux and per-requester ready.
  always_comb begin
    grant   = (state == ST_LOCKED) ? lock_idx : rr_pick;
    gi      = int'(grant);
    a_valid = reset && ((state == ST_LOCKED) ? in_tl.a_valid[grant] : |eligible);
    a_fire  = a_valid && out_tl.a_ready[0];

    in_tl.a_ready = '0;
    if (reset && out_tl.a_ready[0] && (state == ST_LOCKED || eligible[grant]))
      in_tl.a_ready[grant] = 1'b1;

    inc = '0;
    if (a_fire) inc[grant] = 1'b1;

    out_tl.a_valid[0]        = a_valid;
    out_tl.a_bits_opcode     = in_tl.a_bits_opcode[3*gi +: 3];
    out_tl.a_bits_param      = in_tl.a_bits_param[3*gi +: 3];
    out_tl.a_bits_size       = in_tl.a_bits_size[2*gi +: 2];
    out_tl.a_bits_source     = {grant, in_tl.a_bits_source[SRC_W*gi +: SRC_W]};
    out_tl.a_bits_address    = in_tl.a_bits_address[29*gi +: 29];
    out_tl.a_bits_mask       = in_tl.a_bits_mask[8*gi +: 8];
    out_tl.a_bits_data       = in_tl.a_bits_data[64*gi +: 64];
    out_tl.a_bits_corrupt[0] = in_tl.a_bits_corrupt[gi];
  end

  // D routing: the index above the requester source picks the lane; unknown
  // indices are sunk so the crossing never wedges on a bad response.
  always_comb begin
    d_idx    = out_tl.d_bits_source[SRC_W +: IDX_W];
    d_mapped = 1'b0;
    d_sel    = '0;
    for (int i = 0; i < N; i++) begin
      if (d_idx == idx_t'(i)) begin
        d_mapped = 1'b1;
        d_sel[i] = 1'b1;
      end
    end
    in_tl.d_valid     = (reset && out_tl.d_valid[0]) ? d_sel : '0;
    out_tl.d_ready[0] = reset && (d_mapped ? |(d_sel & in_tl.d_ready) : 1'b1);
    d_fire            = out_tl.d_valid[0] && out_tl.d_ready[0];
    dec               = d_fire ? d_sel : '0;
  end

  assign in_tl.d_bits_opcode = out_tl.d_bits_opcode;
  assign in_tl.d_bits_size   = out_tl.d_bits_size;
  assign in_tl.d_bits_source = out_tl.d_bits_source[SRC_W-1:0];
  assign in_tl.d_bits_data   = out_tl.d_bits_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      lock_idx     <= '0;
      err_unmapped <= 1'b0;
      // NOTE: the counter array is a handful of flops, so every entry is reset.
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      if (a_valid && !out_tl.a_ready[0]) lock_idx <= grant;
      if (a_fire) rr_ptr <= (grant == idx_t'(N - 1)) ? '0 : grant + idx_t'(1);
      if (out_tl.d_valid[0] && !d_mapped) err_unmapped <= 1'b1;
      for (int i = 0; i < N; i++) begin
        if (inc[i] && !dec[i] && cnt[i] != cnt_t'(MAX_OUT))
          cnt[i] <= cnt[i] + cnt_t'(1);
        else if (dec[i] && !inc[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - cnt_t'(1);
      end
    end
  end

  // Protocol checks: a locked requester must hold its beat, and no response
  // may arrive for a requester with nothing outstanding.
  a_lock_held : assert property (@(posedge clock) disable iff (!reset)
    (state == ST_LOCKED) |-> in_tl.a_valid[lock_idx]);

  a_no_underflow : assert property (@(posedge clock) disable iff (!reset)
    !(|(dec & cnt_zero)));

endmodule

// File: tb/tb_tl_ctrl_xing_arbiter.sv
// Bench for tl_ctrl_xing_arbiter: directed scenarios plus randomized traffic
// checked every cycle against an integer-level arbitration/credit model.
module tb_tl_ctrl_xing_arbiter;
  localparam int N       = 4;
  localparam int SRC_W   = 9;
  localparam int IDX_W   = 2;
  localparam int MAX_OUT = 4;
  localparam int OSRC_W  = SRC_W + IDX_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic err_unmapped, err3;
  always #5 clock = ~clock;

  tl_ctrl_xing_arbiter_if #(.LANES(N), .SRC_W(SRC_W))  in_tl ();
  tl_ctrl_xing_arbiter_if #(.LANES(1), .SRC_W(OSRC_W)) out_tl ();
  tl_ctrl_xing_arbiter_if #(.LANES(3), .SRC_W(SRC_W))  in3 ();
  tl_ctrl_xing_arbiter_if #(.LANES(1), .SRC_W(OSRC_W)) out3 ();

  tl_ctrl_xing_arbiter #(.N(N), .SRC_W(SRC_W), .IDX_W(IDX_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset), .in_tl(in_tl), .out_tl(out_tl), .err_unmapped(err_unmapped));

  tl_ctrl_xing_arbiter #(.N(3), .SRC_W(SRC_W), .IDX_W(IDX_W), .MAX_OUT(MAX_OUT)) dut3 (
    .clock(clock), .reset(reset), .in_tl(in3), .out_tl(out3), .err_unmapped(err3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pointer, lock and outstanding counts as plain integers.
  int m_rr, m_lock, m_lidx;
  int m_cnt [N];
  int e_g, e_didx;
  bit e_av, e_dr, e_afire, e_dfire;
  logic [N-1:0] e_ar, e_dv;

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lidx = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_eval();
    bit elig [N];
    for (int i = 0; i < N; i++) elig[i] = in_tl.a_valid[i] && (m_cnt[i] < MAX_OUT);
    e_av = 0; e_g = m_rr; e_ar = '0;
    if (m_lock != 0) begin
      e_g = m_lidx; e_av = in_tl.a_valid[m_lidx];
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!e_av && elig[idx]) begin e_av = 1; e_g = idx; end
      end
    end
    if (m_lock != 0 || e_av) e_ar[e_g] = out_tl.a_ready[0];
    e_afire = e_av && out_tl.a_ready[0];
    e_didx = int'(out_tl.d_bits_source[SRC_W +: IDX_W]);
    e_dv = '0;
    e_dv[e_didx] = out_tl.d_valid[0];
    e_dr = in_tl.d_ready[e_didx];
    e_dfire = out_tl.d_valid[0] && e_dr;
  endtask

  task automatic model_commit();
    if (e_afire) begin
      m_cnt[e_g]++; m_rr = (e_g + 1) % N; m_lock = 0;
    end else if (e_av) begin
      m_lock = 1; m_lidx = e_g;
    end
    if (e_dfire) m_cnt[e_didx]--;
  endtask

  task automatic check_outputs();
    logic [IDX_W-1:0] gidx;
    gidx = e_g[IDX_W-1:0];
    check("a_valid", out_tl.a_valid[0], e_av);
    check("a_ready", in_tl.a_ready, e_ar);
    check("d_valid", in_tl.d_valid, e_dv);
    check("d_ready", out_tl.d_ready[0], e_dr);
    check("err_unmapped", err_unmapped, 0);
    if (e_av) begin
      check("a_source", out_tl.a_bits_source, {gidx, in_tl.a_bits_source[SRC_W*e_g +: SRC_W]});
      check("a_address", out_tl.a_bits_address, in_tl.a_bits_address[29*e_g +: 29]);
      check("a_data", out_tl.a_bits_data, in_tl.a_bits_data[64*e_g +: 64]);
      check("a_opcode", out_tl.a_bits_opcode, in_tl.a_bits_opcode[3*e_g +: 3]);
    end
    if (out_tl.d_valid[0]) check("d_source", in_tl.d_bits_source, out_tl.d_bits_source[SRC_W-1:0]);
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    #1;
    model_eval();
    check_outputs();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic set_a(input logic [N-1:0] v, input logic rdy);
    in_tl.a_valid = v;
    out_tl.a_ready[0] = rdy;
  endtask

  task automatic set_d(input logic vld, input logic [OSRC_W-1:0] src, input logic [N-1:0] rdy);
    out_tl.d_valid[0] = vld;
    out_tl.d_bits_source = src;
    in_tl.d_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_random(input int d_pct);
    int cand [$];
    bit held;
    for (int i = 0; i < N; i++) begin
      held = (m_lock != 0) && (m_lidx == i);
      in_tl.a_valid[i] = held ? 1'b1 : ($urandom_range(99) < 55);
      if (!held) begin
        in_tl.a_bits_opcode[3*i +: 3]      = 3'($urandom);
        in_tl.a_bits_source[SRC_W*i +: SRC_W] = SRC_W'($urandom);
        in_tl.a_bits_address[29*i +: 29]   = 29'($urandom);
        in_tl.a_bits_data[64*i +: 64]      = {$urandom, $urandom};
      end
      in_tl.d_ready[i] = ($urandom_range(99) < 70);
      if (m_cnt[i] > 0) cand.push_back(i);
    end
    out_tl.a_ready[0] = ($urandom_range(99) < 65);
    if (cand.size() != 0 && $urandom_range(99) < d_pct) begin
      int k;
      k = cand[$urandom_range(cand.size() - 1)];
      out_tl.d_valid[0] = 1'b1;
      out_tl.d_bits_source = {IDX_W'(k), SRC_W'($urandom)};
      out_tl.d_bits_data = {$urandom, $urandom};
    end else begin
      out_tl.d_valid[0] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin
      in_tl.a_bits_opcode[3*i +: 3]         = 3'd4;
      in_tl.a_bits_param[3*i +: 3]          = 3'd0;
      in_tl.a_bits_size[2*i +: 2]           = 2'd3;
      in_tl.a_bits_source[SRC_W*i +: SRC_W] = SRC_W'(9'h0A0 + i);
      in_tl.a_bits_address[29*i +: 29]      = 29'(i * 'h100);
      in_tl.a_bits_mask[8*i +: 8]           = 8'hFF;
      in_tl.a_bits_data[64*i +: 64]         = 64'(64'hD0 + i);
      in_tl.a_bits_corrupt[i]               = 1'b0;
    end
    out_tl.d_bits_opcode = 3'd1; out_tl.d_bits_size = 2'd3; out_tl.d_bits_data = '0;
    in3.a_valid = '0; in3.a_bits_opcode = '0; in3.a_bits_param = '0; in3.a_bits_size = '0;
    in3.a_bits_source = '0; in3.a_bits_address = '0; in3.a_bits_mask = '0;
    in3.a_bits_data = '0; in3.a_bits_corrupt = '0; in3.d_ready = '0;
    out3.a_ready = '0; out3.d_valid = '0; out3.d_bits_opcode = '0; out3.d_bits_size = '0;
    out3.d_bits_source = '0; out3.d_bits_data = '0;

    // Held in reset with traffic offered: everything must stay quiet.
    set_a('1, 1'b1);
    set_d(1'b1, 11'h655, '1);
    #12;
    check("rst_a_valid", out_tl.a_valid[0], 0);
    check("rst_a_ready", in_tl.a_ready, 0);
    check("rst_d_valid", in_tl.d_valid, 0);
    check("rst_d_ready", out_tl.d_ready[0], 0);
    check("rst_err", err_unmapped, 0);
    set_a('0, 1'b0);
    set_d(1'b0, '0, '0);
    #10;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Round-robin rotation with everyone requesting.
    set_a('1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_source", out_tl.a_bits_source, OSRC_W'(((k % 4) << 9) | (9'h0A0 + (k % 4))));
      cycle();
    end
    set_a(4'b0010, 1'b1);
    cycle();

    // Stalled beat from req1 keeps the grant even though req0 would win now.
    for (int k = 1; k <= 5; k++) begin
      set_a((k == 1) ? 4'b0010 : 4'b0011, 1'b0);
      #1;
      check("stall_source", out_tl.a_bits_source, 11'h2A1);
      check("stall_address", out_tl.a_bits_address, 29'h100);
      cycle();
    end
    set_a(4'b0011, 1'b1);
    #1;
    check("stall_fire_src", out_tl.a_bits_source, 11'h2A1);
    check("stall_fire_rdy", in_tl.a_ready, 4'b0010);
    cycle();
    #1;
    check("after_stall_src", out_tl.a_bits_source, 11'h0A0);
    check("after_stall_rdy", in_tl.a_ready, 4'b0001);
    cycle();
    set_a('0, 1'b0);
    do_reset();

    // Outstanding cap on req2, released by one response.
    set_a(4'b0100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cap_ready", in_tl.a_ready, 4'b0100);
      cycle();
    end
    #1;
    check("cap_full_ready", in_tl.a_ready, 0);
    check("cap_full_valid", out_tl.a_valid[0], 0);
    cycle();
    set_d(1'b1, 11'h433, '1);
    #1;
    check("cap_d_ready_a", in_tl.a_ready, 0);
    check("cap_d_valid", in_tl.d_valid, 4'b0100);
    check("cap_d_ready", out_tl.d_ready[0], 1);
    cycle();
    set_d(1'b0, '0, '1);
    #1;
    check("cap_reopen", in_tl.a_ready, 4'b0100);
    cycle();
    set_a('0, 1'b1);

    // D routing with back-pressure on req3.
    set_a(4'b1000, 1'b1);
    repeat (4) cycle();
    set_a('0, 1'b1);
    set_d(1'b1, 11'h6AB, '0);
    #1;
    check("d3_valid", in_tl.d_valid, 4'b1000);
    check("d3_source", in_tl.d_bits_source, 9'h0AB);
    check("d3_ready_low", out_tl.d_ready[0], 0);
    cycle();
    set_d(1'b1, 11'h6AB, 4'b1000);
    #1;
    check("d3_ready_high", out_tl.d_ready[0], 1);
    cycle();
    set_d(1'b0, '0, '0);
    set_a(4'b1000, 1'b1);
    #1;
    check("d3_decrement", in_tl.a_ready, 4'b1000);
    cycle();
    set_a('0, 1'b0);

    // Unmapped index on the three-requester build.
    out3.d_valid[0] = 1'b1;
    out3.d_bits_source = 11'h655;
    #1;
    check("unmap_ready", out3.d_ready[0], 1);
    check("unmap_d_valid", in3.d_valid, 0);
    check("unmap_err_pre", err3, 0);
    cycle();
    check("unmap_err_set", err3, 1);
    out3.d_valid[0] = 1'b0;
    repeat (3) cycle();
    check("unmap_err_sticky", err3, 1);

    // Reset in the middle of a lock with two beats outstanding on req1.
    set_a(4'b0010, 1'b1);
    repeat (2) cycle();
    set_a(4'b0010, 1'b0);
    cycle();
    reset = 1'b0;
    set_d(1'b1, 11'h400, '1);
    #1;
    check("midrst_a_valid", out_tl.a_valid[0], 0);
    check("midrst_a_ready", in_tl.a_ready, 0);
    check("midrst_d_valid", in_tl.d_valid, 0);
    check("midrst_d_ready", out_tl.d_ready[0], 0);
    set_d(1'b0, '0, '0);
    set_a('0, 1'b0);
    do_reset();
    check("midrst_err3", err3, 0);
    set_a('1, 1'b1);
    #1;
    check("midrst_first_grant", out_tl.a_bits_source, 11'h0A0);
    repeat (8) cycle();
    set_a('0, 1'b0);
    do_reset();

    // Randomized traffic: response-starved, then response-heavy.
    for (int c = 0; c < 1500; c++) begin
      drive_random((c < 750) ? 25 : 75);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tl_ctrl_xing_arbiter.md
Name: tl_ctrl_xing_arbiter

Overview:
- Shares one TileLink-UL control-crossing port (8-byte beats, 29-bit address) between N requesters.
- Arbitration is round-robin with a locked grant, so a stalled A beat is never switched or retracted.
- Requester index is prepended to the A source; D responses are routed back by that index.
- A per-requester outstanding counter caps in-flight transactions.
- Sits directly upstream of the control-crossing fragmenter/coupler.

Parameters:
- N, 4, number of requesters (2..8)
- SRC_W, 9, requester source width
- IDX_W, 2, index width = clog2(N); out source width = SRC_W+IDX_W (default 11)
- MAX_OUT, 4, max in-flight transactions per requester (1..15)

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-low (asserted at 0)
- in_a_valid  input  N  per-requester A valid
- in_a_ready  output  N  per-requester A ready
- in_a_bits_opcode  input  3N  packed, requester i at [3i+:3]
- in_a_bits_param  input  3N  packed
- in_a_bits_size  input  2N  packed
- in_a_bits_source  input  SRC_W*N  packed
- in_a_bits_address  input  29N  packed
- in_a_bits_mask  input  8N  packed
- in_a_bits_data  input  64N  packed
- in_a_bits_corrupt  input  N  packed
- in_d_valid  output  N  per-requester D valid
- in_d_ready  input  N  per-requester D ready
- in_d_bits_opcode  output  3  broadcast to all requesters
- in_d_bits_size  output  2  broadcast
- in_d_bits_source  output  SRC_W  low SRC_W bits of out D source
- in_d_bits_data  output  64  broadcast
- out_a_valid/ready, out_a_bits_{opcode 3, param 3, size 2, source SRC_W+IDX_W, address 29, mask 8, data 64, corrupt 1}  output/input  shared crossing A channel
- out_d_valid/ready, out_d_bits_{opcode 3, size 2, source SRC_W+IDX_W, data 64}  input/output  shared crossing D channel
- err_unmapped  output  1  sticky: D arrived with index >= N

Behaviour:
- Reset (reset==0, async) values: rr_ptr=0; lock=0; lock_idx=0; all cnt[i]=0; err_unmapped=0.
- During reset: out_a_valid=0, in_a_ready=0, in_d_valid=0, out_d_ready=0.
- eligible[i] = in_a_valid[i] && cnt[i] < MAX_OUT.
- Arbitration, when lock=0: grant goes to the first eligible index at or after rr_ptr, wrapping modulo N. Decision is combinational, zero latency.
- When lock=1: grant = lock_idx, regardless of other requests.
- out_a_valid = lock ? in_a_valid[lock_idx] : |eligible.
- out_a bits = granted requester's bits; out_a_bits_source = {grant index, in source}.
- in_a_ready[g] = out_a_ready for the granted g only; 0 for all other requesters.
- Lock set (lock<=1, lock_idx<=g) when out_a_valid && !out_a_ready. Lock cleared on A fire.
- On A fire: rr_ptr <= (g+1) mod N.
- A requester dropping valid while locked violates protocol. Arbiter asserts in simulation and holds the lock.
- D routing: idx = out_d_bits_source[SRC_W+:IDX_W].
  - idx < N: in_d_valid[idx] = out_d_valid; out_d_ready = in_d_ready[idx]; other in_d_valid = 0.
  - idx >= N: response is sunk (out_d_ready=1, no in_d_valid) and err_unmapped is set; it clears only on reset.
- Counters:
  - cnt[i] increments on A fire from i and decrements on D fire to i.
  - Both in the same cycle: unchanged.
  - Saturates at MAX_OUT; a requester at MAX_OUT is ineligible (in_a_ready=0) until a D fires.
  - Decrement at 0 is illegal: hold 0 and assert.
- No combinational path from in_d_ready to in_a_ready, or from out_a_ready to out_a_valid.

Test Plan:
- Requesters 0..3 all valid continuously, out_a_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out sources 0x000|src, 0x200|src, 0x400|src, 0x600|src.
- Req1 granted, out_a_ready=0 for 5 cycles while req0 raises valid -> out_a stays req1's beat, unchanged every cycle; req1 fires on cycle 6, req0 granted on cycle 7.
- Req2 issues 4 A beats with no D -> cnt[2]=4, in_a_ready[2]=0; D with source 0x4xx fires -> cnt[2]=3, req2 eligible next cycle.
- D source 0x6AB, in_d_ready[3]=0 -> in_d_valid[3]=1, in_d_bits_source=0x0AB, out_d_ready=0; raise in_d_ready[3] -> handshake completes, cnt[3] decrements.
- N=3 build, D index 3 -> out_d_ready=1, no in_d_valid, err_unmapped=1 and stays 1.
- Assert reset low mid-lock with cnt[1]=2 -> out_a_valid=0 immediately; after release rr_ptr=0, cnt all 0, lock=0, err_unmapped=0.
